// File: rtl/fir_feeder_pkg.sv
// ---------------------------------------------------------------------------
// fir_feeder_pkg
// Shared types and constants for the FIR stream feeder.
//   state_t     : feeder control FSM states
//   SRC_RD_LAT  : source BRAM read latency in cycles
//   FIFO_DEPTH  : entries in the output skid buffer; also the cap on
//                 (buffered samples + reads in flight)
// ---------------------------------------------------------------------------
package fir_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SRC_RD_LAT = 1;
    localparam int FIFO_DEPTH = 2;

endpackage : fir_feeder_pkg

// File: rtl/axis_fifo2.sv
// ---------------------------------------------------------------------------
// axis_fifo2
// Two-entry register FIFO carrying a data word plus a 'last' flag. The head
// entry is held in dedicated registers so the stream outputs are driven
// straight from flops.
//   axis_clk, axis_rst : clock, synchronous active-high reset
//   push, push_data, push_last : write side (ignored when full and not popping)
//   pop                : read side (ignored when empty)
//   head_data, head_last : current head entry (head_last is 0 when empty)
//   full, empty        : occupancy flags
// Simultaneous push and pop on a full FIFO keeps the occupancy at two.
// ---------------------------------------------------------------------------
module axis_fifo2 #(
    parameter int DW = 32
) (
    input  logic          axis_clk,
    input  logic          axis_rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic          full,
    output logic          empty
);

    logic          head_valid;
    logic          tail_valid;
    logic [DW-1:0] tail_data;
    logic          tail_last;

    logic do_pop;
    logic do_push;
    logic head_from_in;
    logic head_from_tail;
    logic tail_from_in;

    assign do_pop  = pop & head_valid;
    assign do_push = push & (~tail_valid | do_pop);

    // Incoming word lands in the head when the FIFO is (or is about to be)
    // empty; otherwise it goes behind whatever remains at the head.
    assign head_from_in   = do_push & (~head_valid | (do_pop & ~tail_valid));
    assign head_from_tail = do_pop & tail_valid;
    assign tail_from_in   = do_push & head_valid & (tail_valid ? do_pop : ~do_pop);

    assign full  = tail_valid;
    assign empty = ~head_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
            head_data  <= '0;
            head_last  <= 1'b0;
        end else begin
            head_valid <= (head_valid & ~(do_pop & ~tail_valid)) | do_push;
            tail_valid <= tail_valid ? ~(do_pop & ~do_push)
                                     : (do_push & head_valid & ~do_pop);
            if (head_from_in) begin
                head_data <= push_data;
                head_last <= push_last;
            end else if (head_from_tail) begin
                head_data <= tail_data;
                head_last <= tail_last;
            end else if (do_pop) begin
                head_last <= 1'b0;
            end
        end
    end

    // NOTE: the tail payload has no reset; it is only ever read after a push
    // has written it, and tail_valid (which is reset) guards every use.
    always_ff @(posedge axis_clk) begin
        if (tail_from_in) begin
            tail_data <= push_data;
            tail_last <= push_last;
        end
    end

endmodule : axis_fifo2

// File: rtl/fir_stream_feeder.sv
// ---------------------------------------------------------------------------
// fir_stream_feeder
// On a start pulse, reads 'length' consecutive words from a BRAM-style source
// memory and streams them onto the FIR's AXI-Stream slave port, flagging the
// final sample with ss_tlast. A two-entry buffer absorbs the BRAM read latency
// and stream back-pressure, giving one beat per cycle while ss_tready is high.
//   axis_clk, axis_rst : clock, synchronous active-high reset
//   start, base_addr, length : transfer request (sampled only when idle)
//   busy, done         : transfer in progress / one-cycle completion pulse
//   src_EN, src_WE, src_A, src_Di, src_Do : source BRAM port (read only)
//   ss_tvalid, ss_tdata, ss_tlast, ss_tready : AXI-Stream master to the FIR
// ---------------------------------------------------------------------------
module fir_stream_feeder
    import fir_feeder_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,

    input  logic                   start,
    input  logic [pADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]            length,
    output logic                   busy,
    output logic                   done,

    output logic                   src_EN,
    output logic [3:0]             src_WE,
    output logic [pADDR_WIDTH-1:0] src_A,
    output logic [pDATA_WIDTH-1:0] src_Di,
    input  logic [pDATA_WIDTH-1:0] src_Do,

    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready
);

    state_t                   state;
    logic [pADDR_WIDTH-1:0]   base_r;
    logic [31:0]              len_r;
    logic [31:0]              rd_cnt;   // reads issued this transfer
    logic [31:0]              tx_cnt;   // beats accepted this transfer

    // One bit per read still inside the BRAM pipeline, plus whether that
    // read fetches the final sample.
    logic [SRC_RD_LAT-1:0]    rd_pend;
    logic                     rd_pend_last;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     handshake;
    logic                     issue;
    logic                     issue_last;
    logic [2:0]               slots_used;

    assign src_WE = 4'b0000;
    assign src_Di = '0;

    assign ss_tvalid = ~fifo_empty;
    assign handshake = ss_tvalid & ss_tready;

    // Buffered entries plus reads in flight, with a beat leaving this cycle
    // already counted as a free slot; this is what lets a full-rate stream
    // keep issuing while the buffer holds one entry and one read is pending.
    assign slots_used = {2'b00, ~fifo_empty} + {2'b00, fifo_full}
                      + {2'b00, rd_pend[SRC_RD_LAT-1]} - {2'b00, handshake};

    assign issue      = (state == RUN) && (rd_cnt < len_r)
                        && (slots_used < 3'(FIFO_DEPTH));
    assign issue_last = (rd_cnt == len_r - 32'd1);

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        src_EN = 1'b0;
        src_A  = '0;
        if (issue) begin
            src_EN = 1'b1;
            // Byte address wraps naturally at the pADDR_WIDTH boundary.
            src_A  = base_r + {rd_cnt[pADDR_WIDTH-3:0], 2'b00};
        end
    end

    axis_fifo2 #(
        .DW (pDATA_WIDTH)
    ) u_fifo (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .push      (rd_pend[SRC_RD_LAT-1]),
        .push_data (src_Do),
        .push_last (rd_pend_last),
        .pop       (handshake),
        .head_data (ss_tdata),
        .head_last (ss_tlast),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            base_r       <= '0;
            len_r        <= '0;
            rd_cnt       <= '0;
            tx_cnt       <= '0;
            rd_pend      <= '0;
            rd_pend_last <= 1'b0;
        end else begin
            rd_pend      <= {SRC_RD_LAT{issue}};
            rd_pend_last <= issue & issue_last;
            if (issue)     rd_cnt <= rd_cnt + 32'd1;
            if (handshake) tx_cnt <= tx_cnt + 32'd1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base_addr;
                        len_r  <= length;
                        rd_cnt <= '0;
                        tx_cnt <= '0;
                        if (length == 32'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake && (tx_cnt == len_r - 32'd1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : fir_stream_feeder

// File: tb/tb_fir_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_feeder
// Scoreboard bench for fir_stream_feeder: each transfer pushes its expected
// read addresses and beats into queues; a negedge monitor pops and compares
// whenever the DUT issues a read or completes a stream handshake.
// ---------------------------------------------------------------------------
module tb_fir_stream_feeder;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          axis_clk  = 1'b0;
    logic          axis_rst  = 1'b1;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   length    = '0;
    logic          busy;
    logic          done;
    logic          src_EN;
    logic [3:0]    src_WE;
    logic [AW-1:0] src_A;
    logic [DW-1:0] src_Di;
    logic [DW-1:0] src_Do    = '0;
    logic          ss_tvalid;
    logic [DW-1:0] ss_tdata;
    logic          ss_tlast;
    logic          ss_tready = 1'b1;

    fir_stream_feeder #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .src_EN    (src_EN),
        .src_WE    (src_WE),
        .src_A     (src_A),
        .src_Di    (src_Di),
        .src_Do    (src_Do),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready)
    );

    always #5 axis_clk = ~axis_clk;

    // Source BRAM model: one-cycle read latency.
    logic [DW-1:0] mem [1024];
    always @(posedge axis_clk) begin
        if (src_EN) src_Do <= mem[src_A[AW-1:2]];
    end

    int cyc = 0;
    always @(posedge axis_clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard queues and monitor logs ----------------
    beat_t         exp_beats [$];
    logic [AW-1:0] exp_addr  [$];

    int beat_n, first_beat_cyc, last_beat_cyc, done_n, done_cyc;
    int en_n, valid_n, busy_n;
    int rd_issued = 0;
    int acc_n     = 0;
    logic  stall_prev = 1'b0;
    beat_t stall_beat;
    beat_t mon_b;
    logic  [AW-1:0] mon_a;

    always @(negedge axis_clk) begin
        if (axis_rst) begin
            stall_prev = 1'b0;
            rd_issued  = 0;
            acc_n      = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", ss_tvalid, 1'b1);
                check("stall_beat_held", {ss_tdata, ss_tlast}, stall_beat);
            end
            if (ss_tvalid) valid_n++;
            if (busy)      busy_n++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (ss_tvalid && ss_tready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", {ss_tdata, ss_tlast}, '0);
                end else begin
                    mon_b = exp_beats.pop_front();
                    check("beat_data", ss_tdata, mon_b.data);
                    check("beat_last", ss_tlast, mon_b.last);
                end
                if (beat_n == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beat_n++;
                acc_n++;
            end
            if (src_EN) begin
                check("reads_outstanding_lt2", (rd_issued - acc_n) < 2, 1'b1);
                if (exp_addr.size() == 0) begin
                    check("unexpected_read", src_A, '1);
                end else begin
                    mon_a = exp_addr.pop_front();
                    check("read_addr", src_A, mon_a);
                end
                rd_issued++;
                en_n++;
            end
            stall_prev = ss_tvalid && !ss_tready;
            stall_beat = {ss_tdata, ss_tlast};
        end
    end

    // ---------------- ss_tready driver ----------------
    // mode 0: always 1, mode 1: repeating 1,0,0,1,0,1, mode 2: always 0
    int         tr_mode = 0;
    int         pat_idx = 0;
    logic [5:0] tr_pat  = 6'b101001;
    always @(posedge axis_clk) begin
        #1;
        case (tr_mode)
            0:       ss_tready = 1'b1;
            1: begin
                ss_tready = tr_pat[pat_idx % 6];
                pat_idx++;
            end
            default: ss_tready = 1'b0;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_n = 0; done_n = 0; en_n = 0; valid_n = 0; busy_n = 0;
        first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    endtask

    task automatic load_expect(input logic [AW-1:0] base, input int len);
        logic  [AW-1:0] a;
        beat_t          b;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(4 * i);
            b.data = mem[a[AW-1:2]];
            b.last = (i == len - 1);
            exp_addr.push_back(a);
            exp_beats.push_back(b);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input int len, output int k);
        start     = 1'b1;
        base_addr = base;
        length    = len;
        step();
        k     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            step();
            n++;
        end
        if (done_n == 0) check("done_timeout", 1'b0, 1'b1);
        repeat (4) step();
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input int len, input int mode,
                            input int repulse, output int k);
        tr_mode = mode;
        clear_logs();
        load_expect(base, len);
        pulse_start(base, len, k);
        if (repulse > 0) begin
            repeat (repulse) step();
            start     = 1'b1;
            base_addr = 12'h800;
            length    = 5;
            step();
            start = 1'b0;
        end
        wait_done(4 * len + 40);
        check("done_pulses", done_n, 1);
        check("beat_count", beat_n, len);
        check("beats_left", exp_beats.size(), 0);
        check("reads_left", exp_addr.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   busy,      1'b0);
        check({tag, "_done"},   done,      1'b0);
        check({tag, "_src_EN"}, src_EN,    1'b0);
        check({tag, "_src_A"},  src_A,     '0);
        check({tag, "_tvalid"}, ss_tvalid, 1'b0);
        check({tag, "_tdata"},  ss_tdata,  '0);
        check({tag, "_tlast"},  ss_tlast,  1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int n;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i * 7);
        mem[0]    = 32'd10;
        mem[1]    = 32'd20;
        mem[2]    = 32'd30;
        mem[3]    = 32'd40;
        mem[1023] = 32'hDEAD_BEEF;

        // Reset state
        clear_logs();
        repeat (3) step();
        check_reset_vals("rst");
        check("rst_src_WE", src_WE, 4'b0000);
        check("rst_src_Di", src_Di, '0);
        axis_rst = 1'b0;
        repeat (2) step();

        // 1) four samples, full rate, exact timing
        run_xfer(12'h000, 4, 0, 0, k);
        check("t1_first_beat_cycle", first_beat_cyc, k + 2);
        check("t1_last_beat_cycle",  last_beat_cyc,  k + 5);
        check("t1_done_cycle",       done_cyc,       k + 6);
        check("t1_busy_cycles",      busy_n,         6);
        check("t1_reads",            en_n,           4);

        // 2) same data with ss_tready toggling
        run_xfer(12'h000, 4, 1, 0, k);
        check("t2_reads", en_n, 4);

        // 3) zero length
        run_xfer(12'h000, 0, 0, 0, k);
        check("t3_reads",      en_n,     0);
        check("t3_valid",      valid_n,  0);
        check("t3_busy",       busy_n,   0);
        check("t3_done_cycle", done_cyc, k);

        // 4) address wrap 0xFFC -> 0x000
        run_xfer(12'hFFC, 2, 0, 0, k);
        check("t4_reads", en_n, 2);

        // 5) long transfer with a start re-pulse mid-stream
        run_xfer(12'h040, 400, 1, 50, k);
        check("t5_reads", en_n, 400);

        // 6) reset after 3 of 8 beats with the stream stalled
        tr_mode = 0;
        clear_logs();
        load_expect(12'h000, 8);
        pulse_start(12'h000, 8, k);
        n = 0;
        while (beat_n < 3 && n < 100) begin
            @(posedge axis_clk);
            n++;
        end
        tr_mode = 2;
        if (beat_n < 3) check("t6_beat_timeout", 1'b0, 1'b1);
        #1;
        axis_rst = 1'b1;
        step();
        check_reset_vals("t6_rst");
        check("t6_beats_before_rst", beat_n, 3);
        axis_rst = 1'b0;
        exp_beats.delete();
        exp_addr.delete();
        repeat (4) step();
        check("t6_no_done_after_rst", done_n, 0);
        check("t6_idle_after_rst",    busy,   1'b0);
        run_xfer(12'h000, 2, 0, 0, k);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fir_stream_feeder

// File: doc/fir_stream_feeder.md
# fir_stream_feeder

Upstream stage of the FIR engine: on a start pulse, reads `length` consecutive 32-bit samples from a BRAM-style source memory and streams them into the FIR's AXI-Stream slave port (`ss_*`), asserting `ss_tlast` on the final sample. It absorbs the one-cycle BRAM read latency and FIR back-pressure with a two-entry buffer, so it sustains one beat per cycle when `ss_tready` stays high.

## Interface
- Clocking and reset: one clock; reset is synchronous and active-high (ports `axis_clk`, `axis_rst`).
- `pADDR_WIDTH`, default 12: byte-address width of the source memory.
- `pDATA_WIDTH`, default 32: sample width.
- `axis_clk`  in  1  clock.
- `axis_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only when idle.
- `base_addr`  in  pADDR_WIDTH  byte address of sample 0; word-aligned.
- `length`  in  32  number of samples; 0 is legal.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `src_EN`  out  1  BRAM enable; high only for a read.
- `src_WE`  out  4  tied 4'b0000.
- `src_A`  out  pADDR_WIDTH  BRAM byte address.
- `src_Di`  out  pDATA_WIDTH  tied 0.
- `src_Do`  in  pDATA_WIDTH  BRAM read data, valid the cycle after the `src_EN` edge.
- `ss_tvalid`  out  1  stream valid.
- `ss_tdata`  out  pDATA_WIDTH  sample.
- `ss_tlast`  out  1  high with the final sample only.
- `ss_tready`  in  1  FIR accepts.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: issuing and streaming.
  - DONE: one cycle, `done`=1, then IDLE.
- Transitions:
  - IDLE→RUN when `start`=1 and `length`≠0. Latch `base_addr` and `length`; clear the issue counter `rd_cnt` and the send counter `tx_cnt`.
  - IDLE→DONE when `start`=1 and `length`=0. No read and no beat occur.
  - RUN→DONE on the handshake (`ss_tvalid`&`ss_tready`) where `tx_cnt`=`length`-1.
  - `start` in RUN or DONE is ignored.
- Read issue:
  - Condition: in RUN, with `rd_cnt`<`length` and (buffered entries + reads in flight) < 2, counting an entry popped this cycle as free.
  - On issue: `src_EN`=1, `src_A`=`base_addr`+4·`rd_cnt`. Address arithmetic wraps modulo 2^pADDR_WIDTH.
- Data return: `src_Do` is pushed into the 2-entry FIFO on the edge after the issue edge. The FIFO head drives `ss_tdata`. `ss_tvalid` = FIFO non-empty.
- `ss_tlast` = `ss_tvalid` and the head is sample index `length`-1.
- Ordering: samples are emitted strictly in address order. No beat is dropped or duplicated under any `ss_tready` pattern.
- Full/empty: simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Reset, including mid-transfer: state returns to IDLE and the FIFO and counters clear. The in-flight read is discarded and no partial `done` is generated.

## Timing
- Reset values of all outputs: `busy`=0, `done`=0, `src_EN`=0, `src_A`=0, `ss_tvalid`=0, `ss_tdata`=0, `ss_tlast`=0.
- `start` sampled at edge k: `busy`=1 from k; first `src_EN`=1 in cycle k→k+1; first `ss_tvalid`=1 from edge k+2.
- With `ss_tready` held high: one beat per cycle; N samples occupy edges k+2 … k+N+1; `done` is high for the cycle after the last handshake, and `busy` falls together with `done`.
- `length`=0: `done` pulses in the cycle after edge k; `busy` stays 0.
- `ss_tdata`/`ss_tlast` are held stable while `ss_tvalid`=1 and `ss_tready`=0. `ss_tvalid` never drops without a handshake.
- Output timing: all outputs come from registers, except `src_EN`/`src_A`, which are combinational from registered state and the FIFO pop.

## Structure
- `fir_feeder_pkg`:
  - state enum {IDLE, RUN, DONE}
  - `SRC_RD_LAT` = 1
  - `FIFO_DEPTH` = 2
- Sub-module `axis_fifo2`: 2-entry register FIFO with push/pop/full/empty and data+last payload. Reusable on the FIR output side.

## Test plan
- Memory words 10,20,30,40 at 0x000, `base_addr`=0x000, `length`=4, `ss_tready`=1 → beats 10,20,30,40 on four consecutive cycles starting two cycles after `start`; `ss_tlast` only on 40; one `done` pulse.
- Same stimulus, `ss_tready` toggling 1,0,0,1,0,1… → same data order, data held stable while stalled, `src_EN` never issues with two entries outstanding, no loss or duplication.
- `length`=0 → no `src_EN`, no `ss_tvalid`, single `done` pulse the cycle after `start`.
- `base_addr`=0xFFC, `length`=2 → reads at 0xFFC then 0x000; `ss_tlast` on the second beat.
- `length`=400 with `start` re-pulsed mid-stream → second `start` ignored; exactly 400 beats, `ss_tlast` on beat 399.
- `axis_rst` asserted after 3 of 8 beats, `ss_tready`=0 → next cycle all outputs at reset values; a new `start` with `length`=2 streams samples 0 and 1 correctly.
